swallow_counter: RTL and testbench

Modulus controller for the 4/5 dual-modulus prescaler (mc=0 → ÷5, mc=1 → ÷4). It is clocked by the prescaler output and drives the prescaler's mc input.
- Each output period spans P prescaler cycles.
- The first S cycles run ÷5 and the remaining P−S cycles run ÷4, so the total divide ratio is N = 4P + S VCO cycles.
- New P/S values are taken once per output period, so the fractional-N modulator can update N every reference cycle.

---
 rtl/swallow_counter.sv | 78 +++++++
 tb/tb_swallow_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/swallow_counter.sv
// Modulus controller for a 4/5 dual-modulus prescaler: each output period spans P prescaler
// cycles, the first S of which divide by 5 (mc=0) and the rest by 4 (mc=1), giving N = 4P + S.
module swallow_counter #(
  parameter int PW = 6,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] p_in,
  input  logic [SW-1:0] s_in,
  output logic          mc,
  output logic          div_out,
  output logic          ratio_ack,
  output logic          ratio_err
);

  // Common width so S/P comparisons stay unsigned and lossless whichever field is wider.
  localparam int CW = (PW > SW) ? PW : SW;

  logic [PW-1:0] idx;
  logic [PW-1:0] p_lat;
  logic [SW-1:0] s_lat;

  logic          terminal;
  logic [PW-1:0] idx_inc;
  logic [PW-1:0] p_new;
  logic [SW-1:0] s_new;
  logic          clamp;

  assign terminal = (idx == p_lat - PW'(1));
  assign idx_inc  = idx + PW'(1);

  // Ratio sanitising: P=0 becomes 1, and S is never allowed to exceed P.
  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    p_new = p_in;
    s_new = s_in;
    clamp = 1'b0;
    if (p_in == '0) begin
      p_new = PW'(1);
      clamp = 1'b1;
    end
    if (CW'(s_in) > CW'(p_new)) begin
      s_new = SW'(p_new);
      clamp = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      p_lat     <= PW'(1);
      s_lat     <= '0;
      mc        <= 1'b1;
      div_out   <= 1'b0;
      ratio_ack <= 1'b0;
      ratio_err <= 1'b0;
    end else if (terminal) begin
      idx       <= '0;
      p_lat     <= p_new;
      s_lat     <= s_new;
      mc        <= (s_new == '0);
      div_out   <= 1'b1;
      ratio_ack <= 1'b1;
      ratio_err <= clamp;
    end else begin
      idx       <= idx_inc;
      mc        <= (CW'(idx_inc) >= CW'(s_lat));
      div_out   <= 1'b0;
      ratio_ack <= 1'b0;
      ratio_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_swallow_counter.sv
// Bench for swallow_counter: a 4/5 prescaler model on a 10 ns VCO clock feeds the DUT; a
// scoreboard of per-period expectations is checked by an independent monitor.
module tb_swallow_counter;

  localparam int PW = 6;
  localparam int SW = 3;

  typedef struct {
    int p;       // effective P after clamping
    int s;       // effective S after clamping
    int err;     // expected ratio_err on the sampling edge
    int period;  // expected period length in VCO cycles
  } exp_t;

  logic          vco = 1'b0;
  logic          pclk = 1'b0;
  logic          rst;
  logic [PW-1:0] p_in;
  logic [SW-1:0] s_in;
  logic          mc;
  logic          div_out;
  logic          ratio_ack;
  logic          ratio_err;

  int   vco_cnt = 0;
  int   pc = 3;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  swallow_counter #(.PW(PW), .SW(SW)) dut (
    .clk      (pclk),
    .rst      (rst),
    .p_in     (p_in),
    .s_in     (s_in),
    .mc       (mc),
    .div_out  (div_out),
    .ratio_ack(ratio_ack),
    .ratio_err(ratio_err)
  );

  always #5 vco = ~vco;

  // Prescaler model: divides the VCO by 4 when mc=1 and by 5 when mc=0; rising edge at count 0.
  always @(posedge vco) begin
    vco_cnt++;
    if (pc >= (mc ? 3 : 4)) pc = 0;
    else pc++;
    pclk = (pc < 2);
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push_exp(input int n, input int pe, input int se, input int err, input int period);
    for (int i = 0; i < n; i++) sb.push_back('{pe, se, err, period});
  endtask

  task automatic wait_ack();
    int budget;
    budget = 100;
    while (budget > 0) begin
      @(posedge pclk);
      #1;
      if (ratio_ack) break;
      budget--;
    end
    if (budget == 0) check("ack_timeout", 32'(budget), 32'd1);
  endtask

  // Waits `pre` prescaler edges, presents (p,s), queues n expected periods and waits for n acks.
  task automatic run(input int p, input int s, input int n, input int pe, input int se,
                     input int err, input int period, input int pre);
    if (pre > 0) begin
      repeat (pre) @(posedge pclk);
      #2;
    end
    p_in = PW'(p);
    s_in = SW'(s);
    push_exp(n, pe, se, err, period);
    for (int i = 0; i < n; i++) wait_ack();
  endtask

  // Monitor: checks reset outputs, per-cycle mc, and period length / cycle count at each ack.
  initial begin : monitor
    exp_t cur;
    int   cur_valid;
    int   cyc;
    int   vco_start;
    int   vco_now;
    cur_valid = 0;
    cyc       = 0;
    vco_start = 0;
    forever begin
      @(posedge pclk);
      vco_now = vco_cnt;
      #1;
      if (!rst) begin
        check("rst_mc", 32'(mc), 32'd1);
        check("rst_div_out", 32'(div_out), 32'd0);
        check("rst_ratio_ack", 32'(ratio_ack), 32'd0);
        check("rst_ratio_err", 32'(ratio_err), 32'd0);
        cur_valid = 0;
        continue;
      end
      if (ratio_ack) begin
        if (cur_valid != 0) begin
          check("period_cycles", 32'(cyc), 32'(cur.p));
          check("period_vco", 32'(vco_now - vco_start), 32'(cur.period));
        end
        if (sb.size() == 0) begin
          check("ack_expected", 32'(sb.size()), 32'd1);
          cur_valid = 0;
        end else begin
          cur       = sb.pop_front();
          cur_valid = 1;
          check("ratio_err", 32'(ratio_err), 32'(cur.err));
        end
        vco_start = vco_now;
        cyc       = 0;
      end
      if (cur_valid != 0) begin
        check("mc", 32'(mc), 32'(cyc >= cur.s));
        check("div_out", 32'(div_out), 32'(cyc == 0));
        if (!ratio_ack) check("ratio_err_idle", 32'(ratio_err), 32'd0);
        cyc++;
      end
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst  = 1'b1;
    p_in = PW'(3);
    s_in = SW'(1);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge pclk);
    #2;

    // P=3, S=1 held: 13 VCO cycles per period, mc pattern 0,1,1.
    push_exp(4, 3, 1, 0, 13);
    @(negedge vco);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) wait_ack();

    // P=5, S=0 -> 20; P=2, S=2 -> 10.
    run(5, 0, 3, 5, 0, 0, 20, 0);
    run(2, 2, 3, 2, 2, 0, 10, 0);

    // (4,1) then change to (4,3) mid-period: 17 then 19.
    run(4, 1, 1, 4, 1, 0, 17, 0);
    run(4, 3, 2, 4, 3, 0, 19, 2);

    // Illegal ratios: S>P clamps to S=P; P=0 clamps to P=1.
    run(2, 5, 2, 2, 2, 1, 10, 0);
    run(0, 0, 4, 1, 0, 1, 4, 0);

    // P=6, S=2 period interrupted by reset during idx=2.
    run(6, 2, 1, 6, 2, 0, 26, 0);
    repeat (2) @(posedge pclk);
    #13;
    rst = 1'b0;
    #1;
    check("async_rst_mc", 32'(mc), 32'd1);
    check("async_rst_div_out", 32'(div_out), 32'd0);
    check("async_rst_ratio_ack", 32'(ratio_ack), 32'd0);
    check("async_rst_ratio_err", 32'(ratio_err), 32'd0);
    repeat (3) @(posedge pclk);
    #2;
    push_exp(3, 6, 2, 0, 26);
    @(negedge vco);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) wait_ack();

    repeat (2) @(posedge pclk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
